serial_shift_adder: RTL and testbench

// - Parametrised serial adder/subtractor: two WIDTH-bit operands are loaded in parallel into

---
 rtl/serial_shift_adder.sv | 168 ++++++++++++++++
 tb/tb_serial_shift_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_adder.sv
// rtl/serial_shift_adder.sv - serial LSB-first adder/subtractor with valid/ready handshakes
//
// Purpose:
//   Two WIDTH-bit operands are captured in parallel, then summed LSB-first,
//   BITS_PER_CYCLE bits per clock, with a carry flip-flop linking slices.
//   Subtraction is A + ~B + 1 (B inverted at capture, carry seeded with 1).
//
// Parameters:
//   WIDTH           operand/result width (>= 2)
//   BITS_PER_CYCLE  bits summed per clock (must divide WIDTH)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  block can accept an operand request
//   a, b       in   operands
//   sub        in   0: A+B, 1: A-B
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer accepts the result
//   result     out  sum/difference
//   cout       out  final carry (sub mode: 1 = no borrow)
//   overflow   out  signed overflow
//   acc_sel    in   (SERIAL_ADDER_ACCUM_EN only) take A from the last result
//
// Optional feature macro: SERIAL_ADDER_ACCUM_EN
module serial_shift_adder #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef SERIAL_ADDER_ACCUM_EN
  ,
  input  logic             acc_sel
`endif
);

  localparam int NSL = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = $clog2(NSL + 1);

  generate
    if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("serial_shift_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [WIDTH-1:0]          op_a_q, op_a_d;
  logic [WIDTH-1:0]          op_b_q, op_b_d;
  logic [WIDTH-1:0]          res_q, res_d;
  logic                      carry_q, carry_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [BITS_PER_CYCLE-1:0] a_sl, b_sl;
  logic [BITS_PER_CYCLE:0]   slice_sum;
  logic                      msb_cin;
  logic                      accept;
  logic                      last_shift;
  logic                      shift_done;
  logic [WIDTH-1:0]          a_src;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

`ifdef SERIAL_ADDER_ACCUM_EN
  // res_q only changes in SHIFT, and acceptance never happens in SHIFT, so
  // here it always holds the last completed result (0 after reset).
  assign a_src = acc_sel ? res_q : a;
`else
  assign a_src = a;
`endif

  assign a_sl       = op_a_q[BITS_PER_CYCLE-1:0];
  assign b_sl       = op_b_q[BITS_PER_CYCLE-1:0];
  assign slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{BITS_PER_CYCLE{1'b0}}, carry_q};
  // Carry into the top bit of this slice, recovered from that bit's sum.
  assign msb_cin    = a_sl[BITS_PER_CYCLE-1] ^ b_sl[BITS_PER_CYCLE-1] ^ slice_sum[BITS_PER_CYCLE-1];
  assign last_shift = (cnt_q == CW'(NSL - 1));
  assign shift_done = (cnt_q == CW'(NSL));

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (!shift_done) begin
          op_a_d  = op_a_q >> BITS_PER_CYCLE;
          op_b_d  = op_b_q >> BITS_PER_CYCLE;
          // New slice enters from the MSB end; after NSL slices the LSB slice sits at bit 0.
          res_d   = WIDTH'({slice_sum[BITS_PER_CYCLE-1:0], res_q} >> BITS_PER_CYCLE);
          carry_d = slice_sum[BITS_PER_CYCLE];
          cnt_d   = cnt_q + CW'(1);
          if (last_shift) begin
            cout_d = slice_sum[BITS_PER_CYCLE];
            ovf_d  = msb_cin ^ slice_sum[BITS_PER_CYCLE];
          end
        end else begin
          // Extra cycle after the final slice gives the documented N+1 latency.
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      op_a_d  = a_src;
      op_b_d  = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_shift_adder.sv
// tb/tb_serial_shift_adder.sv - directed self-checking bench for serial_shift_adder
module tb_serial_shift_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
`ifdef SERIAL_ADDER_ACCUM_EN
  logic        acc_sel = 1'b0;
  logic        acc_sel4 = 1'b0;
`endif

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [15:0] result4;
  logic        cout4;
  logic        overflow4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_shift_adder #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
`ifdef SERIAL_ADDER_ACCUM_EN
    , .acc_sel(acc_sel)
`endif
  );

  serial_shift_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(1'b0), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .cout(cout4), .overflow(overflow4)
`ifdef SERIAL_ADDER_ACCUM_EN
    , .acc_sel(acc_sel4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op at the negedge and let the next rising edge accept it.
  task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv);
    @(negedge clk);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    #1 check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge: measures latency and checks outputs.
  task automatic finish_op(input string tag, input logic [15:0] er, input logic ec,
                           input logic eo, input bit consume);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd17);
    check_eq({tag, "_result"}, 32'(result), 32'(er));
    check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(eo));
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_eq({tag, "_consumed"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);

    start_op("add1", 16'h1234, 16'h4321, 1'b0); finish_op("add1", 16'h5555, 1'b0, 1'b0, 1'b1);
    start_op("add2", 16'hFFFF, 16'h0001, 1'b0); finish_op("add2", 16'h0000, 1'b1, 1'b0, 1'b1);
    start_op("add3", 16'h7FFF, 16'h0001, 1'b0); finish_op("add3", 16'h8000, 1'b0, 1'b1, 1'b1);
    start_op("add4", 16'h8000, 16'h8000, 1'b0); finish_op("add4", 16'h0000, 1'b1, 1'b1, 1'b1);
    start_op("sub1", 16'h0005, 16'h0007, 1'b1); finish_op("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    start_op("sub2", 16'h8000, 16'h0001, 1'b1); finish_op("sub2", 16'h7FFF, 1'b1, 1'b1, 1'b1);
    start_op("sub3", 16'hFFFF, 16'hFFFF, 1'b1); finish_op("sub3", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure in DONE, then consume-and-accept in the same cycle.
    start_op("bp", 16'h00F0, 16'h000F, 1'b0);
    finish_op("bp", 16'h00FF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_result", 32'(result), 32'h00FF);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h1000; b = 16'h0234; sub = 1'b0;
    #1 check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    check_eq("b2b_no_bubble", 32'(out_valid), 32'd0);
    finish_op("b2b", 16'h1234, 1'b0, 1'b0, 1'b1);

    // in_valid during SHIFT must be ignored.
    start_op("ign", 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA;
    #1 check_eq("ign_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    begin
      int lat = 1;
      while (!out_valid && lat < 100) begin
        @(posedge clk);
        #1 lat++;
      end
      check_eq("ign_latency", 32'(lat), 32'd17);
      check_eq("ign_result", 32'(result), 32'h0002);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Reset in the middle of SHIFT aborts the operation.
    start_op("rmid", 16'h1111, 16'h2222, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    check_eq("rmid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rmid_in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk);
        #1 if (out_valid) seen++;
      end
      check_eq("rmid_no_result", 32'(seen), 32'd0);
    end

    // BITS_PER_CYCLE = 4 instance.
    @(negedge clk);
    a4 = 16'hABCD; b4 = 16'h1111; in_valid4 = 1'b1;
    #1 check_eq("bpc4_in_ready", 32'(in_ready4), 32'd1);
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    begin
      int lat = 0;
      while (!out_valid4 && lat < 100) begin
        @(posedge clk);
        #1 lat++;
      end
      check_eq("bpc4_latency", 32'(lat), 32'd5);
      check_eq("bpc4_result", 32'(result4), 32'hBCDE);
      check_eq("bpc4_cout", 32'(cout4), 32'd0);
      check_eq("bpc4_ovf", 32'(overflow4), 32'd0);
    end
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1 out_ready4 = 1'b0;

`ifdef SERIAL_ADDER_ACCUM_EN
    acc_sel = 1'b0;
    start_op("acc1", 16'h0003, 16'h0000, 1'b0); finish_op("acc1", 16'h0003, 1'b0, 1'b0, 1'b1);
    @(negedge clk); acc_sel = 1'b1;
    start_op("acc2", 16'h5A5A, 16'h0004, 1'b0);
    acc_sel = 1'b0;
    finish_op("acc2", 16'h0007, 1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
